// File: rtl/router_multi_class.sv
// router_multi_class: 5-port XY mesh router with CLASS_NUMBER independent
// traffic classes per port. Each ingress channel has its own FIFO; each egress
// channel runs an IDLE/BUSY packet-lock FSM with round-robin header arbitration.
// Channel bit layout of in_mosi_i/out_mosi_o elements: {tvalid, tlast, tdata}.
// Optional performance counters are enabled with `define ROUTER_PMU_EN.
module router_multi_class #(
  parameter int AXIS_DATA_WIDTH = 40,
  parameter int CLASS_NUMBER    = 2,
  parameter int BUFFER_LENGTH   = 16,
  parameter int MAX_ROUTERS_X   = 4,
  parameter int MAX_ROUTERS_Y   = 4,
  parameter int ROUTER_X        = 0,
  parameter int ROUTER_Y        = 0,
  localparam int PORT_NUMBER    = 5,
  localparam int CHANNEL_NUMBER = PORT_NUMBER * CLASS_NUMBER,
  localparam int MOSI_W         = AXIS_DATA_WIDTH + 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_n_i,
  input  logic [CHANNEL_NUMBER-1:0][MOSI_W-1:0] in_mosi_i,
  output logic [CHANNEL_NUMBER-1:0]             in_miso_o,
  output logic [CHANNEL_NUMBER-1:0][MOSI_W-1:0] out_mosi_o,
  input  logic [CHANNEL_NUMBER-1:0]             out_miso_i
`ifdef ROUTER_PMU_EN
  ,
  input  logic                                  pmu_clear_i,
  output logic [PORT_NUMBER-1:0][31:0]          pmu_beats_o,
  output logic [PORT_NUMBER-1:0][31:0]          pmu_stall_o
`endif
);

  localparam int X_W    = $clog2(MAX_ROUTERS_X);
  localparam int Y_W    = $clog2(MAX_ROUTERS_Y);
  localparam int PTR_W  = $clog2(BUFFER_LENGTH);
  localparam int PORT_W = 3;
  localparam int BEAT_W = AXIS_DATA_WIDTH + 1;

  localparam logic [X_W-1:0] OWN_X = X_W'(ROUTER_X);
  localparam logic [Y_W-1:0] OWN_Y = Y_W'(ROUTER_Y);

  localparam logic [PORT_W-1:0] P_LOCAL = 3'd0;
  localparam logic [PORT_W-1:0] P_NORTH = 3'd1;
  localparam logic [PORT_W-1:0] P_SOUTH = 3'd2;
  localparam logic [PORT_W-1:0] P_WEST  = 3'd3;
  localparam logic [PORT_W-1:0] P_EAST  = 3'd4;

  typedef struct packed {
    logic                       tvalid;
    logic                       tlast;
    logic [AXIS_DATA_WIDTH-1:0] tdata;
  } axis_mosi_t;

  typedef enum logic {IDLE, BUSY} state_e;

  axis_mosi_t                in_beat    [CHANNEL_NUMBER];
  logic [BEAT_W-1:0]         fifo_mem   [CHANNEL_NUMBER][BUFFER_LENGTH];
  logic [BEAT_W-1:0]         head       [CHANNEL_NUMBER];
  logic [PTR_W:0]            wr_ptr_q   [CHANNEL_NUMBER];
  logic [PTR_W:0]            wr_ptr_d   [CHANNEL_NUMBER];
  logic [PTR_W:0]            rd_ptr_q   [CHANNEL_NUMBER];
  logic [PTR_W:0]            rd_ptr_d   [CHANNEL_NUMBER];
  logic [CHANNEL_NUMBER-1:0] fifo_full, fifo_empty, push, pop;

  logic [CHANNEL_NUMBER-1:0] in_pkt_q, in_pkt_d;
  logic [PORT_W-1:0]         route_q    [CHANNEL_NUMBER];
  logic [PORT_W-1:0]         route_d    [CHANNEL_NUMBER];
  logic [PORT_W-1:0]         route_cur  [CHANNEL_NUMBER];

  state_e                    state_q    [CHANNEL_NUMBER];
  state_e                    state_d    [CHANNEL_NUMBER];
  logic [PORT_W-1:0]         owner_q    [CHANNEL_NUMBER];
  logic [PORT_W-1:0]         owner_d    [CHANNEL_NUMBER];
  logic [PORT_W-1:0]         ptr_q      [CHANNEL_NUMBER];
  logic [PORT_W-1:0]         ptr_d      [CHANNEL_NUMBER];
  logic [CHANNEL_NUMBER-1:0] hold_q, hold_d;
  logic [PORT_W-1:0]         grant      [CHANNEL_NUMBER];
  logic [CHANNEL_NUMBER-1:0] grant_vld, grant_last, out_hs;

  function automatic logic [PORT_W-1:0] xy_route(input logic [AXIS_DATA_WIDTH-1:0] hdr);
    logic [X_W-1:0] tx;
    logic [Y_W-1:0] ty;
    tx = hdr[X_W-1:0];
    ty = hdr[X_W+Y_W-1:X_W];
    if (tx > OWN_X)      xy_route = P_EAST;
    else if (tx < OWN_X) xy_route = P_WEST;
    else if (ty > OWN_Y) xy_route = P_SOUTH;
    else if (ty < OWN_Y) xy_route = P_NORTH;
    else                 xy_route = P_LOCAL;
  endfunction

  // Ingress FIFO status, ready and head; ready is forced low while in reset
  always_comb begin
    for (int unsigned ch = 0; ch < CHANNEL_NUMBER; ch++) begin
      in_beat[ch]    = axis_mosi_t'(in_mosi_i[ch]);
      fifo_empty[ch] = (wr_ptr_q[ch] == rd_ptr_q[ch]);
      fifo_full[ch]  = (wr_ptr_q[ch][PTR_W] != rd_ptr_q[ch][PTR_W]) &&
                       (wr_ptr_q[ch][PTR_W-1:0] == rd_ptr_q[ch][PTR_W-1:0]);
      in_miso_o[ch]  = !fifo_full[ch] && rst_n_i;
      push[ch]       = in_beat[ch].tvalid && in_miso_o[ch];
      head[ch]       = fifo_mem[ch][rd_ptr_q[ch][PTR_W-1:0]];
    end
  end

  // Route of each head beat: decoded from header, or latched for the packet body
  always_comb begin
    for (int unsigned ch = 0; ch < CHANNEL_NUMBER; ch++)
      route_cur[ch] = in_pkt_q[ch] ? route_q[ch] : xy_route(head[ch][AXIS_DATA_WIDTH-1:0]);
  end

  // Per-output arbitration among same-class inputs and combinational egress mux
  always_comb begin
    int unsigned             cls, oport, idx, src;
    logic [PORT_NUMBER-1:0]  req;
    logic                    found;
    cls = 0; oport = 0; idx = 0; src = 0; req = '0; found = 1'b0;
    for (int unsigned o = 0; o < CHANNEL_NUMBER; o++) begin
      cls   = o % CLASS_NUMBER;
      oport = o / CLASS_NUMBER;
      for (int unsigned p = 0; p < PORT_NUMBER; p++)
        req[p] = !fifo_empty[p*CLASS_NUMBER+cls] &&
                 (route_cur[p*CLASS_NUMBER+cls] == PORT_W'(oport));
      grant[o]     = owner_q[o];
      grant_vld[o] = 1'b0;
      // A stalled IDLE grant is pinned via hold_q so the offered beat cannot change
      if (state_q[o] == BUSY || hold_q[o]) begin
        grant_vld[o] = req[owner_q[o]];
      end else begin
        found = 1'b0;
        for (int unsigned k = 0; k < PORT_NUMBER; k++) begin
          idx = (int'(ptr_q[o]) + k) % PORT_NUMBER;
          if (!found && req[idx]) begin
            found        = 1'b1;
            grant[o]     = PORT_W'(idx);
            grant_vld[o] = 1'b1;
          end
        end
      end
      src           = int'(grant[o]) * CLASS_NUMBER + cls;
      out_mosi_o[o] = {grant_vld[o], head[src]};
      grant_last[o] = head[src][AXIS_DATA_WIDTH];
      out_hs[o]     = grant_vld[o] && out_miso_i[o];
    end
  end

  // Dequeue the input channel whose beat was accepted downstream
  always_comb begin
    pop = '0;
    for (int unsigned o = 0; o < CHANNEL_NUMBER; o++)
      if (out_hs[o]) pop[int'(grant[o])*CLASS_NUMBER + (o % CLASS_NUMBER)] = 1'b1;
  end

  // FIFO pointer and input packet-tracking next state
  always_comb begin
    for (int unsigned ch = 0; ch < CHANNEL_NUMBER; ch++) begin
      wr_ptr_d[ch] = wr_ptr_q[ch] + {{PTR_W{1'b0}}, push[ch]};
      rd_ptr_d[ch] = rd_ptr_q[ch] + {{PTR_W{1'b0}}, pop[ch]};
      in_pkt_d[ch] = in_pkt_q[ch];
      route_d[ch]  = route_q[ch];
      if (pop[ch]) begin
        in_pkt_d[ch] = !head[ch][AXIS_DATA_WIDTH];
        route_d[ch]  = route_cur[ch];
      end
    end
  end

  // Output FSM next state: lock on multi-beat header, release on tlast
  always_comb begin
    for (int unsigned o = 0; o < CHANNEL_NUMBER; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      hold_d[o]  = hold_q[o];
      case (state_q[o])
        IDLE: begin
          if (out_hs[o]) begin
            hold_d[o] = 1'b0;
            ptr_d[o]  = PORT_W'((int'(grant[o]) + 1) % PORT_NUMBER);
            if (!grant_last[o]) begin
              state_d[o] = BUSY;
              owner_d[o] = grant[o];
            end
          end else if (grant_vld[o]) begin
            hold_d[o]  = 1'b1;
            owner_d[o] = grant[o];
          end
        end
        BUSY: begin
          if (out_hs[o] && grant_last[o]) state_d[o] = IDLE;
        end
        default: state_d[o] = IDLE;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the pointers qualify them
  always_ff @(posedge clk_i) begin
    for (int unsigned ch = 0; ch < CHANNEL_NUMBER; ch++)
      if (push[ch]) fifo_mem[ch][wr_ptr_q[ch][PTR_W-1:0]] <= {in_beat[ch].tlast, in_beat[ch].tdata};
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      in_pkt_q <= '0;
      hold_q   <= '0;
      for (int unsigned ch = 0; ch < CHANNEL_NUMBER; ch++) begin
        wr_ptr_q[ch] <= '0;
        rd_ptr_q[ch] <= '0;
        route_q[ch]  <= '0;
        state_q[ch]  <= IDLE;
        owner_q[ch]  <= '0;
        ptr_q[ch]    <= '0;
      end
    end else begin
      in_pkt_q <= in_pkt_d;
      hold_q   <= hold_d;
      for (int unsigned ch = 0; ch < CHANNEL_NUMBER; ch++) begin
        wr_ptr_q[ch] <= wr_ptr_d[ch];
        rd_ptr_q[ch] <= rd_ptr_d[ch];
        route_q[ch]  <= route_d[ch];
        state_q[ch]  <= state_d[ch];
        owner_q[ch]  <= owner_d[ch];
        ptr_q[ch]    <= ptr_d[ch];
      end
    end
  end

`ifdef ROUTER_PMU_EN
  logic [PORT_NUMBER-1:0][31:0] beats_q, beats_d, stall_q, stall_d;

  // Saturating per-port egress beat and stall counters; clear beats increment
  always_comb begin
    int unsigned n;
    logic        st;
    n = 0; st = 1'b0;
    beats_d = beats_q;
    stall_d = stall_q;
    for (int unsigned p = 0; p < PORT_NUMBER; p++) begin
      n  = 0;
      st = 1'b0;
      for (int unsigned c = 0; c < CLASS_NUMBER; c++) begin
        n  = n + {31'b0, out_hs[p*CLASS_NUMBER+c]};
        st = st | (grant_vld[p*CLASS_NUMBER+c] && !out_miso_i[p*CLASS_NUMBER+c]);
      end
      if (pmu_clear_i) begin
        beats_d[p] = '0;
        stall_d[p] = '0;
      end else begin
        if ({1'b0, beats_q[p]} + {1'b0, n} > 33'h0_FFFF_FFFF) beats_d[p] = '1;
        else                                                 beats_d[p] = beats_q[p] + n;
        if (st && (stall_q[p] != '1)) stall_d[p] = stall_q[p] + 32'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      beats_q <= '0;
      stall_q <= '0;
    end else begin
      beats_q <= beats_d;
      stall_q <= stall_d;
    end
  end

  assign pmu_beats_o = beats_q;
  assign pmu_stall_o = stall_q;
`endif

endmodule
